spi_slave_ctrl: RTL and testbench
=================================

// Module: spi_slave_ctrl
// PURPOSE
//   SPI slave front end feeding the single-port RAM. Deserialises MOSI frames into
//   10-bit words {cmd[1:0], payload[7:0]} on rx_data/rx_valid.
//   On a read-data command it waits for tx_valid/tx_data from the RAM and serialises
//   the byte onto MISO, MSB first.
//   All logic is clocked on clk; SPI bits are sampled/driven one per clk cycle.
// PARAMETERS
//   RX_W  10  width of rx_data frame (cmd bits in [RX_W-1:RX_W-2])
//   TX_W  8   width of tx_data byte shifted out on MISO
// PORTS
//   clk       in   1     system clock; all logic on posedge
//   rst       in   1     synchronous reset, active-high
//   SS_n      in   1     slave select, active-low; frame boundary
//   MOSI      in   1     serial data in, MSB first
//   MISO      out  1     serial data out, MSB first
//   rx_data   out  RX_W  received word to RAM din
//   rx_valid  out  1     one-cycle strobe, rx_data valid
//   tx_data   in   TX_W  read byte from RAM dout
//   tx_valid  in   1     RAM read byte valid
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0,
//     rd_addr_seen=0. Reset overrides every other condition, including mid-frame.
//   States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//   IDLE: SS_n=0 sampled -> CHK_CMD next cycle; else stay.
//   CHK_CMD: sample MOSI as R/W bit.
//     0 -> WRITE; 1 and rd_addr_seen=0 -> READ_ADD; 1 and rd_addr_seen=1 -> READ_DATA.
//   WRITE/READ_ADD/READ_DATA receive phase: shift MOSI into shift reg for RX_W cycles.
//     On the edge sampling bit RX_W: rx_data <= {shift[RX_W-2:0],MOSI}, rx_valid <= 1.
//     rx_data bits are forwarded verbatim; no check against the R/W bit.
//   rx_valid is high for exactly one cycle per completed frame.
//     rx_data holds its value until the next completed frame.
//   After the receive phase completes:
//     WRITE: idle until SS_n=1.
//     READ_ADD: set rd_addr_seen=1; idle until SS_n=1.
//     READ_DATA: clear rd_addr_seen; enter wait-tx sub-phase.
//   Wait-tx: on the first cycle with tx_valid=1, latch tx_data.
//     tx_valid is ignored outside this sub-phase.
//   Shift-out: MISO = latched[TX_W-1] on the cycle after the latch edge, then the next
//     bits on the following cycles. Exactly TX_W bits are driven; MISO=0 afterwards,
//     until SS_n=1. No timeout in wait-tx.
//   SS_n=1 sampled in any non-IDLE state -> IDLE next cycle: counter cleared, MISO=0,
//     shift-out aborted.
//     A partial frame produces no rx_valid and leaves rd_addr_seen unchanged.
//   MISO is 0 whenever the block is not in shift-out.
//   Frame latency: SS_n falls sampled at edge E0. R/W bit is sampled at E1. Data bits
//     are sampled at E2..E(RX_W+1). rx_valid is high in the cycle after E(RX_W+1).
// TESTING
//   1 rst=1 for 2 cycles during an active READ_DATA shift-out
//     -> MISO=0, rx_valid=0 next cycle; state IDLE.
//   2 SS_n=0, MOSI=0 then 10'b00_1010_0101
//     -> single rx_valid pulse, rx_data=10'h0A5, 12 cycles after SS_n sampled low.
//   3 Frame 1+10'h230, SS_n=1, then frame 1+10'h3FF; RAM returns tx_valid, tx_data=8'hC3
//     -> first frame is routed to READ_ADD with rd_addr_seen=1.
//     -> second frame gives rx_data=10'h3FF and MISO=1,1,0,0,0,0,1,1 on 8 consecutive
//        cycles after the latch; rd_addr_seen=0.
//   4 Read-data frame (1+10'h3AA) with rd_addr_seen=0
//     -> handled as READ_ADD; rx_valid with rx_data=10'h3AA; no MISO activity.
//   5 SS_n=1 after 5 data bits
//     -> IDLE next cycle, no rx_valid; following full write frame decodes correctly.
//   6 tx_valid pulsed during the receive phase, then again in wait-tx with 8'h5A
//     -> only the wait-tx byte 8'h5A is shifted out.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port RAM.
// Each MOSI frame becomes a {cmd, payload} word on rx_data/rx_valid. After a
// read-data frame the block waits for the RAM byte on tx_data/tx_valid and
// shifts it out on MISO, MSB first. Every SPI bit takes one clk cycle.
module spi_slave_ctrl #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    // One counter is shared by the receive phase and the shift-out phase,
    // so it has to be wide enough for the longer of the two.
    localparam int MAX_W = (RX_W > TX_W) ? RX_W : TX_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // What a frame is doing inside WRITE/READ_ADD/READ_DATA:
    //   PH_RX    collecting the RX_W data bits
    //   PH_HOLD  frame done, waiting for SS_n to rise
    //   PH_WAIT  read data only: waiting for the RAM byte
    //   PH_SHIFT read data only: driving the byte on MISO
    typedef enum logic [1:0] {
        PH_RX,
        PH_HOLD,
        PH_WAIT,
        PH_SHIFT
    } phase_t;

    state_t            state_reg;
    state_t            state_next;
    phase_t            phase_reg;
    phase_t            phase_next;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [RX_W-2:0]   shift_reg;
    logic [TX_W-1:0]   tx_shift_reg;
    logic              rd_addr_seen_reg;

    logic rx_last;
    logic tx_last;
    logic in_frame;

    assign rx_last  = (bit_cnt_reg == RX_LAST);
    assign tx_last  = (bit_cnt_reg == TX_LAST);
    assign in_frame = (state_reg == WRITE) || (state_reg == READ_ADD) ||
                      (state_reg == READ_DATA);

    // MISO is only ever non-zero while a byte is actually being shifted out.
    assign MISO = (phase_reg == PH_SHIFT) ? tx_shift_reg[TX_W-1] : 1'b0;

    // State and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            phase_reg <= PH_RX;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    // Next-state logic: SS_n high ends any frame, whatever its progress.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        if (state_reg == IDLE) begin
            phase_next = PH_RX;
            if (!SS_n) begin
                state_next = CHK_CMD;
            end
        end else if (SS_n) begin
            state_next = IDLE;
            phase_next = PH_RX;
        end else if (state_reg == CHK_CMD) begin
            phase_next = PH_RX;
            if (!MOSI) begin
                state_next = WRITE;
            end else if (rd_addr_seen_reg) begin
                state_next = READ_DATA;
            end else begin
                state_next = READ_ADD;
            end
        end else begin
            case (phase_reg)
                PH_RX: begin
                    if (rx_last) begin
                        phase_next = (state_reg == READ_DATA) ? PH_WAIT : PH_HOLD;
                    end
                end
                PH_WAIT: begin
                    if (tx_valid) begin
                        phase_next = PH_SHIFT;
                    end
                end
                PH_SHIFT: begin
                    if (tx_last) begin
                        phase_next = PH_HOLD;
                    end
                end
                default: begin
                    phase_next = PH_HOLD;
                end
            endcase
        end
    end

    // Datapath: receive shifter, output word, read-address flag, TX shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            tx_shift_reg     <= '0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            rd_addr_seen_reg <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!in_frame || SS_n) begin
                // Idle, command bit, or frame aborted: start the next frame clean.
                bit_cnt_reg <= '0;
            end else begin
                case (phase_reg)
                    PH_RX: begin
                        shift_reg <= {shift_reg[RX_W-3:0], MOSI};
                        if (rx_last) begin
                            rx_data     <= {shift_reg, MOSI};
                            rx_valid    <= 1'b1;
                            bit_cnt_reg <= '0;
                            if (state_reg == READ_ADD) begin
                                rd_addr_seen_reg <= 1'b1;
                            end else if (state_reg == READ_DATA) begin
                                rd_addr_seen_reg <= 1'b0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                        end
                    end
                    PH_WAIT: begin
                        bit_cnt_reg <= '0;
                        if (tx_valid) begin
                            tx_shift_reg <= tx_data;
                        end
                    end
                    PH_SHIFT: begin
                        tx_shift_reg <= {tx_shift_reg[TX_W-2:0], 1'b0};
                        bit_cnt_reg  <= tx_last ? '0 : (bit_cnt_reg + CNT_ONE);
                    end
                    default: begin
                        bit_cnt_reg <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: received words go through a
// scoreboard queue, MISO bytes are checked bit by bit against the RAM byte.
module tb_spi_slave_ctrl;

    localparam int RX_W = 10;
    localparam int TX_W = 8;

    logic            clk;
    logic            rst;
    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    int checks = 0;
    int errors = 0;
    logic [RX_W-1:0] sb_q[$];

    spi_slave_ctrl #(.RX_W(RX_W), .TX_W(TX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every rx_valid pulse must match the oldest pushed word.
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            if (sb_q.size() == 0) begin
                check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                logic [RX_W-1:0] exp_w;
                exp_w = sb_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(exp_w));
                $display("rx word %03h (expected %03h)", rx_data, exp_w);
            end
        end
    end

    // Drive one frame: SS_n low, R/W bit, then nbits of word MSB first.
    // A tx_valid pulse can be injected on data bit pulse_bit.
    task automatic send_frame(input logic rw, input logic [RX_W-1:0] word,
                              input int nbits, input int pulse_bit,
                              input logic [TX_W-1:0] pulse_byte);
        if (nbits == RX_W) sb_q.push_back(word);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        MOSI = rw;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = word[RX_W-1-i];
            if (i == pulse_bit) begin
                tx_valid = 1'b1;
                tx_data  = pulse_byte;
            end else begin
                tx_valid = 1'b0;
            end
            tick();
        end
        tx_valid = 1'b0;
        MOSI     = 1'b0;
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        tick();
        check("idle_miso", 32'(MISO), 32'h0);
        tick();
    endtask

    // RAM answers with byte b after two idle wait cycles; check all MISO bits.
    task automatic serve_byte(input logic [TX_W-1:0] b);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wait_miso", 32'(MISO), 32'h0);
        end
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
        tx_data  = '0;
        for (int i = TX_W - 1; i >= 0; i--) begin
            check("miso_bit", 32'(MISO), 32'(b[i]));
            tick();
        end
        check("miso_after", 32'(MISO), 32'h0);
        $display("tx byte %02h shifted out", b);
    endtask

    initial begin
        logic [7:0] b_c3;
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        tick();
        tick();
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        rst = 1'b0;
        tick();

        // Write frame with exact rx_valid timing.
        send_frame(1'b0, 10'h0A5, RX_W, -1, 8'h00);
        check("wr_rxv_hi", 32'(rx_valid), 32'h1);
        tick();
        check("wr_rxv_lo", 32'(rx_valid), 32'h0);
        end_frame();

        // Read address then read data; RAM returns C3.
        send_frame(1'b1, 10'h230, RX_W, -1, 8'h00);
        end_frame();
        send_frame(1'b1, 10'h3FF, RX_W, -1, 8'h00);
        b_c3 = 8'hC3;
        serve_byte(b_c3);
        end_frame();

        // rd_addr_seen is clear again: this frame is a read address, so no MISO.
        send_frame(1'b1, 10'h3AA, RX_W, -1, 8'h00);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rdadd_no_miso", 32'(MISO), 32'h0);
        end
        tx_valid = 1'b0;
        end_frame();

        // Aborted write after 5 bits, then a clean write frame.
        send_frame(1'b0, 10'h3C3, 5, -1, 8'h00);
        end_frame();
        check("abort_hold", 32'(rx_data), 32'h3AA);
        send_frame(1'b0, 10'h155, RX_W, -1, 8'h00);
        end_frame();

        // rd_addr_seen survived the abort: read data, stray tx_valid in receive.
        send_frame(1'b1, 10'h301, RX_W, 3, 8'hFF);
        serve_byte(8'h5A);
        end_frame();

        // Reset in the middle of a shift-out.
        send_frame(1'b1, 10'h210, RX_W, -1, 8'h00);
        end_frame();
        send_frame(1'b1, 10'h3F0, RX_W, -1, 8'h00);
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_miso", 32'(MISO), 32'h1);
        rst  = 1'b1;
        SS_n = 1'b1;
        tick();
        check("mid_rst_miso", 32'(MISO), 32'h0);
        check("mid_rst_rxv", 32'(rx_valid), 32'h0);
        tick();
        rst = 1'b0;
        check("post_rst_data", 32'(rx_data), 32'h0);
        tick();
        check("post_rst_miso", 32'(MISO), 32'h0);

        // After reset a read frame is a read address again; check a write too.
        send_frame(1'b0, 10'h07E, RX_W, -1, 8'h00);
        end_frame();
        send_frame(1'b1, 10'h2CD, RX_W, -1, 8'h00);
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_rdadd", 32'(MISO), 32'h0);
        end
        tx_valid = 1'b0;
        end_frame();

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
